ahb_cmd_master: RTL and testbench

- AHB-Lite initiator that turns one-shot commands from a local requester into AHB transfers.
- Each command is either one SINGLE transfer or one INCR4 burst.
- It drives the same HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HWDATA bus that the system's AHB slave decoder (register file, timer/WD/PWM) consumes, and returns read data and per-command status to the requester.

---
 rtl/ahb_cmd_master.sv | 207 ++++++++++++++++++++
 tb/tb_ahb_cmd_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cmd_master.sv
// rtl/ahb_cmd_master.sv - AHB-Lite initiator turning one-shot commands into SINGLE or INCR4 transfers
module ahb_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic                    cmd_incr4,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [2:0]              cmd_size,
  input  logic [4*DATA_WIDTH-1:0] cmd_wdata,
  output logic [ADDR_WIDTH-1:0]   HADDR,
  output logic [1:0]              HTRANS,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [2:0]              HBURST,
  output logic [3:0]              HPROT,
  output logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic                    HREADY,
  input  logic                    HRESP,
  input  logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    done,
  output logic                    done_err
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam int         MAX_SIZE     = $clog2(DATA_WIDTH / 8);

  // S_ADDR: first beat NONSEQ, no data phase yet
  // S_BURST: SEQ address of beat n overlaps data phase of beat n-1
  // S_LAST: only the final outstanding data phase remains
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              beat_q, beat_d;
  logic                    err_q, err_d;
  logic [4*DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
  logic [1:0]              htrans_q, htrans_d;
  logic                    hwrite_q, hwrite_d;
  logic [2:0]              hsize_q, hsize_d;
  logic [2:0]              hburst_q, hburst_d;
  logic [DATA_WIDTH-1:0]   hwdata_q, hwdata_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic                    accept;
  logic                    reject;
  logic                    data_done;
  logic [7:0]              align_mask;
  logic [10:0]             burst_end;
  logic [ADDR_WIDTH-1:0]   addr_step;
  logic [DATA_WIDTH-1:0]   beat_wdata;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = cmd_valid & cmd_ready;

  // A command is refused if too wide for the bus, misaligned, or an INCR4 spilling past a 1 KB page
  assign align_mask = (8'd1 << cmd_size) - 8'd1;
  assign burst_end  = {1'b0, cmd_addr[9:0]} + (11'd4 << cmd_size);
  assign reject     = (int'(cmd_size) > MAX_SIZE)
                   || ((cmd_addr[7:0] & align_mask) != 8'd0)
                   || (cmd_incr4 && (burst_end > 11'd1024));

  assign addr_step  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << hsize_q;
  assign beat_wdata = wdata_q[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH];

  assign HADDR    = haddr_q;
  assign HTRANS   = htrans_q;
  assign HWRITE   = hwrite_q;
  assign HSIZE    = hsize_q;
  assign HBURST   = hburst_q;
  assign HPROT    = 4'b0011;
  assign HWDATA   = hwdata_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign done     = (state_q == S_DONE);
  assign done_err = (state_q == S_DONE) && err_q;

  // Next-state and next bus values; every bus register holds unless an HREADY edge advances it
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    err_d      = err_q;
    wdata_d    = wdata_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hburst_d   = hburst_q;
    hwdata_d   = hwdata_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    data_done  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d  = S_IDLE;
        htrans_d = TRANS_IDLE;
        if (accept) begin
          err_d = reject;
          if (reject) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_ADDR;
            beat_d   = 2'd0;
            wdata_d  = cmd_wdata;
            haddr_d  = cmd_addr;
            htrans_d = TRANS_NONSEQ;
            hwrite_d = cmd_write;
            hsize_d  = cmd_size;
            hburst_d = cmd_incr4 ? BURST_INCR4 : BURST_SINGLE;
          end
        end
      end

      S_ADDR: begin
        if (HREADY) begin
          hwdata_d = beat_wdata;
          if (hburst_q == BURST_INCR4) begin
            state_d  = S_BURST;
            beat_d   = beat_q + 2'd1;
            haddr_d  = haddr_q + addr_step;
            htrans_d = TRANS_SEQ;
          end else begin
            state_d  = S_LAST;
            htrans_d = TRANS_IDLE;
          end
        end
      end

      S_BURST: begin
        if (HREADY) begin
          data_done = 1'b1;
          hwdata_d  = beat_wdata;
          // On ERROR the beat just accepted still runs its data phase, nothing further is issued
          if (HRESP || (beat_q == 2'd3)) begin
            state_d  = S_LAST;
            htrans_d = TRANS_IDLE;
          end else begin
            beat_d   = beat_q + 2'd1;
            haddr_d  = haddr_q + addr_step;
            htrans_d = TRANS_SEQ;
          end
        end
      end

      S_LAST: begin
        if (HREADY) begin
          data_done = 1'b1;
          state_d   = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (data_done && HRESP) begin
      err_d = 1'b1;
    end
    if (data_done && !hwrite_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = HRDATA;
    end
  end

  // State and registered bus outputs; reset discards any command in flight
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      beat_q     <= 2'd0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      haddr_q    <= '0;
      htrans_q   <= TRANS_IDLE;
      hwrite_q   <= 1'b0;
      hsize_q    <= 3'b010;
      hburst_q   <= BURST_SINGLE;
      hwdata_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      wdata_q    <= wdata_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hburst_q   <= hburst_d;
      hwdata_q   <= hwdata_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb/tb_ahb_cmd_master.sv - randomized self-checking bench for ahb_cmd_master with slave and memory model
module tb_ahb_cmd_master;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int APW = AW + 2 + 1 + 3 + 3;
  localparam logic [112:0] RST_VEC = {2'b00, 32'h0, 1'b0, 3'b010, 3'b000, 4'b0011,
                                      32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          cmd_valid, cmd_ready, cmd_write, cmd_incr4;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_size;
  logic [4*DW-1:0] cmd_wdata;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic [DW-1:0] HWDATA, HRDATA, rd_data;
  logic          HREADY, HRESP, rd_valid, done, done_err;

  ahb_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_incr4(cmd_incr4),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .done_err(done_err)
  );

  always #5 HCLK = ~HCLK;

  int unsigned cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [APW-1:0] aq[$];
  logic [DW-1:0]  rdq[$];
  logic [DW-1:0]  wq[$];
  logic [DW-1:0]  slave_mem [int unsigned];
  logic [DW-1:0]  ref_mem   [int unsigned];

  int   err_beat = -1;
  int   forced_stalls = 0;
  int   stall_pct = 0;
  int   ready_cnt = 0;
  int   done_count = 0;
  int   done_cyc = 0;
  int   done_ready = 0;
  logic done_err_seen = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
    return a ^ 32'hC3A5_0000;
  endfunction

  function automatic logic [112:0] out_vec();
    return {HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
            cmd_ready, rd_valid, rd_data, done, done_err};
  endfunction

  // Slave + monitor: acts at each falling edge, its HREADY/HRESP/HRDATA take effect on the next rising edge
  initial begin : slave
    logic          dp_act, dp_wr, prev_stall;
    logic [AW-1:0] dp_addr;
    int            dp_beat, stall_left;
    logic [72:0]   cur_bus, prev_bus;
    dp_act = 0; dp_wr = 0; prev_stall = 0; dp_addr = '0;
    dp_beat = 0; stall_left = 0; prev_bus = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (rd_valid) rdq.push_back(rd_data);
      if (done) begin
        done_count++;
        done_cyc      = cyc;
        done_ready    = ready_cnt;
        done_err_seen = done_err;
      end
      if (HRESET) begin
        dp_act = 0; prev_stall = 0; HREADY = 1'b1; HRESP = 1'b0;
      end else begin
        cur_bus = {HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA};
        if (prev_stall) chk("stall_hold", cur_bus, prev_bus);
        HRESP = 1'b0;
        if (!dp_act) HREADY = 1'b1;
        else if (stall_left > 0) begin HREADY = 1'b0; stall_left--; end
        else HREADY = ($urandom_range(99) >= stall_pct);
        if (HREADY && dp_act) begin
          if (dp_beat == err_beat) HRESP = 1'b1;
          if (dp_wr) begin
            wq.push_back(HWDATA);
            if (!HRESP) slave_mem[dp_addr] = HWDATA;
          end else begin
            HRDATA = slave_mem.exists(dp_addr) ? slave_mem[dp_addr] : fill(dp_addr);
          end
        end
        if (HREADY) begin
          ready_cnt++;
          if (HTRANS[1]) begin
            aq.push_back({HADDR, HTRANS, HWRITE, HSIZE, HBURST});
            if (HTRANS == 2'b10) begin dp_beat = 0; stall_left = forced_stalls; end
            else dp_beat++;
            dp_act = 1; dp_addr = HADDR; dp_wr = HWRITE;
          end else begin
            dp_act = 0;
          end
        end
        prev_stall = !HREADY;
        prev_bus   = cur_bus;
      end
    end
  end

  task automatic issue(input logic w, input logic i4, input logic [AW-1:0] a, input logic [2:0] sz,
                       input logic [4*DW-1:0] wd, output int base, output int r0, output bit ok);
    ok = 0; base = 0; r0 = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge HCLK); #2;
      ok = cmd_ready;
    end
    if (!ok) begin chk("ready_timeout", 0, 1); return; end
    cmd_valid = 1'b1; cmd_write = w; cmd_incr4 = i4; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    base = cyc;
    r0   = ready_cnt;
  endtask

  // Expected behaviour from command semantics: beat addresses, completed beats, data, latency
  task automatic run_cmd(input logic w, input logic i4, input logic [AW-1:0] a, input logic [2:0] sz,
                         input logic [4*DW-1:0] wd, input int eb, input int fst);
    int nb, bytes, last, base, r0, dc0, d;
    bit rej, ok, got;
    logic [AW-1:0] ba;
    logic [DW-1:0] ev;
    nb    = i4 ? 4 : 1;
    bytes = 1 << sz;
    rej   = (sz > 3'd2) || ((a % bytes) != 0) || (i4 && ((a % 1024) + 4 * bytes > 1024));
    err_beat      = (!rej && eb >= 0 && eb < nb) ? eb : -1;
    forced_stalls = fst;
    last = (err_beat >= 0 && err_beat + 1 < nb) ? err_beat + 1 : nb - 1;
    aq.delete(); rdq.delete(); wq.delete();
    dc0 = done_count;
    issue(w, i4, a, sz, wd, base, r0, ok);
    if (!ok) return;
    got = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(posedge HCLK); #1;
      got = (done_count != dc0);
    end
    if (!got) begin chk("done_timeout", 0, 1); return; end
    d = done_cyc - base + 1;
    chk("done_err", done_err_seen, rej || (err_beat >= 0));
    if (rej) begin
      chk("rej_cycle", d, 1);
      chk("rej_no_bus", aq.size(), 0);
      return;
    end
    chk("aphase_count", aq.size(), last + 1);
    for (int n = 0; n <= last && n < aq.size(); n++) begin
      ba = a + n * bytes;
      chk("aphase", aq[n], {ba, (n == 0) ? 2'b10 : 2'b11, w, sz, i4 ? 3'b011 : 3'b000});
    end
    chk("ready_cycles", done_ready - r0, last + 2);
    if (stall_pct == 0) chk("done_cycle", d, last + 3 + fst);
    if (w) begin
      chk("wbeats", wq.size(), last + 1);
      for (int n = 0; n <= last; n++) begin
        ba = a + n * bytes;
        if (n < wq.size()) chk("hwdata", wq[n], wd[n*DW +: DW]);
        if (n != err_beat) ref_mem[ba] = wd[n*DW +: DW];
      end
      chk("no_rd_valid", rdq.size(), 0);
    end else begin
      chk("rbeats", rdq.size(), last + 1);
      for (int n = 0; n <= last && n < rdq.size(); n++) begin
        ba = a + n * bytes;
        ev = ref_mem.exists(ba) ? ref_mem[ba] : fill(ba);
        chk("rdata", rdq[n], ev);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, r0, dc0;
    bit ok;
    logic w, i4;
    logic [2:0] sz;
    logic [AW-1:0] a;
    logic [4*DW-1:0] wd;
    int eb;

    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_incr4 = 1'b0;
    cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    repeat (3) @(posedge HCLK);
    #1 chk("reset_in", out_vec(), RST_VEC);
    @(negedge HCLK); #2 HRESET = 1'b0;
    @(posedge HCLK); #1 chk("reset_out", out_vec(), RST_VEC);

    stall_pct = 0;
    run_cmd(1'b1, 1'b0, 32'h0, 3'd2, 128'h0A, -1, 0);
    run_cmd(1'b0, 1'b0, 32'h0, 3'd2, '0, -1, 0);
    run_cmd(1'b1, 1'b1, 32'h0, 3'd2, {32'd4, 32'd3, 32'd2, 32'd1}, -1, 0);
    run_cmd(1'b0, 1'b1, 32'h0, 3'd2, '0, -1, 0);
    run_cmd(1'b0, 1'b0, 32'h4000_0014, 3'd2, '0, -1, 3);
    run_cmd(1'b1, 1'b1, 32'h100, 3'd2, {32'hD4, 32'hC3, 32'hB2, 32'hA1}, 1, 0);
    run_cmd(1'b0, 1'b1, 32'h100, 3'd2, '0, -1, 0);
    run_cmd(1'b1, 1'b1, 32'h3F8, 3'd2, '0, -1, 0);
    run_cmd(1'b0, 1'b0, 32'h2, 3'd2, '0, -1, 0);
    run_cmd(1'b0, 1'b1, 32'h3F0, 3'd2, '0, -1, 0);

    // Reset while beat 2 address phase is on the bus
    err_beat = -1; forced_stalls = 0;
    dc0 = done_count;
    issue(1'b1, 1'b1, 32'h1000, 3'd2, {32'd44, 32'd33, 32'd22, 32'd11}, base, r0, ok);
    @(posedge HCLK); @(posedge HCLK); #1;
    chk("rst_pre_beat2", {HADDR, HTRANS}, {32'h1008, 2'b11});
    @(negedge HCLK); #2 HRESET = 1'b1;
    #1 chk("rst_async", out_vec(), RST_VEC);
    repeat (2) @(negedge HCLK);
    #2 HRESET = 1'b0;
    repeat (4) @(posedge HCLK);
    #1 chk("rst_no_done", done_count, dc0);
    run_cmd(1'b1, 1'b1, 32'h40, 3'd2, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 0);
    run_cmd(1'b0, 1'b1, 32'h40, 3'd2, '0, -1, 0);

    stall_pct = 25;
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(1));
      i4 = 1'($urandom_range(1));
      sz = ($urandom_range(9) == 0) ? 3'd3 : 3'($urandom_range(2));
      a  = $urandom_range(2047);
      if ($urandom_range(3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      wd = {$urandom, $urandom, $urandom, $urandom};
      eb = ($urandom_range(5) == 0) ? int'($urandom_range(3)) : -1;
      run_cmd(w, i4, a, sz, wd, eb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
